// File: rtl/mcbsp_rx_frame_buf.sv
// Double-banked frame buffer between a McBSP receiver and a DSP consumer.
// Writer fills one bank per hop frame while the reader drains the other, one word per handshake.
module mcbsp_rx_frame_buf #(
  parameter int FRAME_WORDS = 721,
  parameter int ADDR_W      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_ready,
  input  logic [31:0] rx_data_in,
  input  logic        transform_en,
  input  logic        out_ready,
  input  logic        ovf_clr,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic [1:0]  bank_full,
  output logic [15:0] frame_cnt,
  output logic        overflow,
  output logic [15:0] drop_cnt,
  output logic        wr_abort
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_WORDS - 1);

  typedef enum logic {W_IDLE, W_FILL} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_HOLD} r_state_e;

  logic [31:0] mem [0:(2**(ADDR_W+1))-1];

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic              rx_ready_q;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              wr_abort_q, wr_abort_d;
  logic [31:0]       rd_data_q, rd_data_d;

  logic       strobe;
  logic       wr_en;
  logic       drop;
  logic [1:0] wr_set;
  logic [1:0] rd_clr;

  // Rising edge of rx_ready: one word per pulse however long the level lasts.
  assign strobe = rx_ready & ~rx_ready_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      rx_ready_q  <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_ptr_q    <= '0;
      bank_full_q <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      wr_abort_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      rx_ready_q  <= rx_ready;
      wr_bank_q   <= wr_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_bank_q   <= rd_bank_d;
      rd_ptr_q    <= rd_ptr_d;
      bank_full_q <= bank_full_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      wr_abort_q  <= wr_abort_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // NOTE: the frame storage has no reset; its contents are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank_q, wr_ptr_q}] <= rx_data_in;
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if (transform_en) w_state_d = W_FILL;
      W_FILL:  if (!transform_en) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Writer datapath; the full test uses the registered flags, so a bank freed this cycle still drops.
  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_ptr_d   = wr_ptr_q;
    wr_en      = 1'b0;
    wr_set     = '0;
    drop       = 1'b0;
    wr_abort_d = 1'b0;
    if (w_state_q == W_FILL) begin
      if (!transform_en) begin
        wr_ptr_d   = '0;
        wr_abort_d = (wr_ptr_q != '0);
      end else if (strobe) begin
        if (bank_full_q[wr_bank_q]) begin
          drop = 1'b1;
        end else begin
          wr_en = 1'b1;
          if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d          = '0;
            wr_bank_d         = ~wr_bank_q;
            wr_set[wr_bank_q] = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    if (wr_set != '0) frame_cnt_d = frame_cnt_q + 16'd1;
    if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (bank_full_q[rd_bank_q]) r_state_d = R_READ;
      R_READ:  r_state_d = R_HOLD;
      R_HOLD:  if (out_ready) r_state_d = (rd_ptr_q == LAST_PTR) ? R_IDLE : R_READ;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rd_bank_d = rd_bank_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    rd_clr    = '0;
    unique case (r_state_q)
      R_IDLE: if (bank_full_q[rd_bank_q]) rd_ptr_d = '0;
      R_READ: rd_data_d = mem[{rd_bank_q, rd_ptr_q}];
      R_HOLD: begin
        if (out_ready) begin
          if (rd_ptr_q == LAST_PTR) begin
            rd_clr[rd_bank_q] = 1'b1;
            rd_bank_d         = ~rd_bank_q;
            rd_ptr_d          = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Set and clear always target different banks, so both apply together.
  assign bank_full_d = (bank_full_q & ~rd_clr) | wr_set;

  always_comb begin
    out_valid = (r_state_q == R_HOLD);
    out_sof   = out_valid && (rd_ptr_q == '0);
    out_eof   = out_valid && (rd_ptr_q == LAST_PTR);
  end

  assign out_data  = rd_data_q;
  assign bank_full = bank_full_q;
  assign frame_cnt = frame_cnt_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign wr_abort  = wr_abort_q;

endmodule

// File: tb/tb_mcbsp_rx_frame_buf.sv
// Bench for mcbsp_rx_frame_buf: frame-queue reference model compared every cycle, plus directed literal checks.
module tb_mcbsp_rx_frame_buf;

  localparam int FW = 4;
  localparam int AW = 2;

  logic        clk;
  logic        rst;
  logic        rx_ready;
  logic [31:0] rx_data_in;
  logic        transform_en;
  logic        out_ready;
  logic        ovf_clr;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic [1:0]  bank_full;
  logic [15:0] frame_cnt;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        wr_abort;

  mcbsp_rx_frame_buf #(.FRAME_WORDS(FW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data_in(rx_data_in),
    .transform_en(transform_en), .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .bank_full(bank_full), .frame_cnt(frame_cnt), .overflow(overflow),
    .drop_cnt(drop_cnt), .wr_abort(wr_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames as a word queue, banks implied by completed/retired frame counts.
  int          m_written = 0;
  int          m_read    = 0;
  logic [31:0] m_words[$];
  logic [31:0] m_partial[$];
  bit          m_active = 0;
  bit          m_rx_prev = 0;
  bit          m_out_valid = 0;
  bit          m_fetch = 0;
  int          m_idx = 0;
  bit          m_abort = 0;
  bit          m_overflow = 0;
  logic [15:0] m_frame_cnt = '0;
  logic [15:0] m_drop_cnt = '0;

  task automatic model_reset();
    m_written = 0; m_read = 0;
    m_words.delete(); m_partial.delete();
    m_active = 0; m_rx_prev = 0; m_out_valid = 0; m_fetch = 0; m_idx = 0;
    m_abort = 0; m_overflow = 0; m_frame_cnt = '0; m_drop_cnt = '0;
  endtask

  task automatic model_step();
    bit strobe, complete, retire, drop;
    int buffered;
    strobe = rx_ready && !m_rx_prev;
    m_rx_prev = rx_ready;
    buffered = m_written - m_read;
    complete = 0; retire = 0; drop = 0;
    m_abort = 0;
    if (!m_active) begin
      if (transform_en) m_active = 1;
    end else if (!transform_en) begin
      m_abort = (m_partial.size() != 0);
      m_partial.delete();
      m_active = 0;
    end else if (strobe) begin
      if (buffered == 2) drop = 1;
      else begin
        m_partial.push_back(rx_data_in);
        if (m_partial.size() == FW) begin
          foreach (m_partial[i]) m_words.push_back(m_partial[i]);
          m_partial.delete();
          complete = 1;
        end
      end
    end
    if (ovf_clr) begin
      m_overflow = 0; m_drop_cnt = '0;
    end else if (drop) begin
      m_overflow = 1;
      if (m_drop_cnt != 16'hFFFF) m_drop_cnt++;
    end
    if (m_out_valid && out_ready) begin
      m_out_valid = 0;
      if (m_idx == FW - 1) begin retire = 1; m_idx = 0; end
      else begin m_idx++; m_fetch = 1; end
    end else if (m_fetch) begin
      m_fetch = 0; m_out_valid = 1;
    end else if (!m_out_valid && buffered > 0) begin
      m_fetch = 1; m_idx = 0;
    end
    if (complete) begin m_written++; m_frame_cnt++; end
    if (retire) begin
      m_read++;
      repeat (FW) if (m_words.size() > 0) void'(m_words.pop_front());
    end
  endtask

  function automatic logic [1:0] exp_bank_full();
    int buffered;
    logic [1:0] bf;
    buffered = m_written - m_read;
    bf = '0;
    if (buffered >= 2) bf = 2'b11;
    else if (buffered == 1) bf[m_read % 2] = 1'b1;
    return bf;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step();
  end

  // Compare process and handshake monitor, sampled on the falling edge.
  logic [33:0] hs_q[$];
  int          abort_cnt = 0;
  bit          prev_valid = 0;
  bit          prev_ready = 0;
  logic [31:0] prev_data = '0;

  initial forever begin
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(m_out_valid));
    if (m_out_valid)
      check("out_data", 64'(out_data), 64'((m_idx < m_words.size()) ? m_words[m_idx] : 32'hDEAD_BEEF));
    check("out_sof", 64'(out_sof), 64'(m_out_valid && m_idx == 0));
    check("out_eof", 64'(out_eof), 64'(m_out_valid && m_idx == FW - 1));
    check("bank_full", 64'(bank_full), 64'(exp_bank_full()));
    check("frame_cnt", 64'(frame_cnt), 64'(m_frame_cnt));
    check("overflow", 64'(overflow), 64'(m_overflow));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop_cnt));
    check("wr_abort", 64'(wr_abort), 64'(m_abort));
    if (!rst && prev_valid && !prev_ready) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'(out_data), 64'(prev_data));
    end
    prev_valid = out_valid && !rst;
    prev_ready = out_ready;
    prev_data  = out_data;
    if (!rst && out_valid && out_ready) hs_q.push_back({out_sof, out_eof, out_data});
    if (!rst && wr_abort) abort_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic [31:0] d, input int hold);
    rx_data_in = d;
    rx_ready   = 1'b1;
    repeat (hold) step();
    rx_ready = 1'b0;
    step();
  endtask

  task automatic wait_hs(input string name, input int n, input int budget);
    int i;
    i = 0;
    while (hs_q.size() < n && i < budget) begin step(); i++; end
    check(name, 64'(hs_q.size() >= n), 64'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    i = 0;
    while (!(m_written == m_read && !m_out_valid && !m_fetch) && i < budget) begin step(); i++; end
    check(name, 64'(m_written == m_read && !m_out_valid && !m_fetch), 64'd1);
  endtask

  function automatic logic [63:0] hs_at(input int i);
    return (i < hs_q.size()) ? 64'(hs_q[i]) : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  logic [31:0] sent[8];

  initial begin
    rst = 1'b1;
    rx_ready = 1'b0; rx_data_in = '0; transform_en = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_bank_full", 64'(bank_full), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    step();

    // One frame A0..A3 with a ready consumer.
    transform_en = 1'b1; out_ready = 1'b1;
    step(); step();
    for (int i = 0; i < FW; i++) send_word(32'hA0 + 32'(i), 1);
    wait_hs("t1_hs_timeout", FW, 100);
    check("t1_w0", hs_at(0), 64'({2'b10, 32'hA0}));
    check("t1_w1", hs_at(1), 64'({2'b00, 32'hA1}));
    check("t1_w2", hs_at(2), 64'({2'b00, 32'hA2}));
    check("t1_w3", hs_at(3), 64'({2'b01, 32'hA3}));
    wait_idle("t1_drain_timeout", 50);
    step();
    check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t1_bank_full", 64'(bank_full), 64'd0);

    // Long rx_ready levels: exactly one word per pulse.
    hs_q.delete();
    for (int i = 0; i < 2 * FW; i++) begin
      sent[i] = $urandom;
      send_word(sent[i], 10);
    end
    wait_hs("t2_hs_timeout", 2 * FW, 200);
    repeat (30) step();
    check("t2_word_count", 64'(hs_q.size()), 64'(2 * FW));
    for (int i = 0; i < 2 * FW; i++) check($sformatf("t2_w%0d", i), hs_at(i) & 64'hFFFF_FFFF, 64'(sent[i]));
    check("t2_frame_cnt", 64'(frame_cnt), 64'd3);

    // Stalled consumer: third frame is dropped word by word.
    out_ready = 1'b0;
    for (int i = 0; i < 3 * FW; i++) send_word(32'hC000 + 32'(i), 1);
    repeat (4) step();
    check("t3_bank_full", 64'(bank_full), 64'd3);
    check("t3_overflow", 64'(overflow), 64'd1);
    check("t3_drop_cnt", 64'(drop_cnt), 64'd4);
    check("t3_frame_cnt", 64'(frame_cnt), 64'd5);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0; step();
    check("t3_clr_overflow", 64'(overflow), 64'd0);
    check("t3_clr_drop_cnt", 64'(drop_cnt), 64'd0);
    out_ready = 1'b1;
    wait_idle("t3_drain_timeout", 100);

    // Abort after two words; the next frame must contain only fresh words.
    hs_q.delete();
    abort_cnt = 0;
    send_word(32'hD0, 1); send_word(32'hD1, 1);
    transform_en = 1'b0; step(); step();
    transform_en = 1'b1; step(); step();
    check("t4_abort_pulses", 64'(abort_cnt), 64'd1);
    for (int i = 0; i < FW; i++) send_word(32'hB0 + 32'(i), 1);
    wait_hs("t4_hs_timeout", FW, 100);
    repeat (10) step();
    check("t4_word_count", 64'(hs_q.size()), 64'(FW));
    check("t4_w0", hs_at(0), 64'({2'b10, 32'hB0}));
    check("t4_w3", hs_at(3), 64'({2'b01, 32'hB3}));

    // Randomized traffic, first with an eager consumer, then a sluggish one.
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 1500; c++) begin
        if (!rx_ready) rx_data_in = $urandom;
        if ($urandom_range(0, 2) == 0) rx_ready = ~rx_ready;
        transform_en = ($urandom_range(0, 149) != 0);
        out_ready = (phase == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
        ovf_clr = ($urandom_range(0, 49) == 0);
        step();
      end
    end

    // Reset while a word is being presented.
    transform_en = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0; rx_ready = 1'b0;
    step();
    wait_idle("t6_drain_timeout", 200);
    transform_en = 1'b1; out_ready = 1'b0;
    step(); step();
    for (int i = 0; i < FW; i++) send_word(32'hE0 + 32'(i), 1);
    for (int i = 0; i < 20 && !m_out_valid; i++) step();
    check("t6_valid_before_rst", 64'(out_valid), 64'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check("t6_rst_bank_full", 64'(bank_full), 64'd0);
    check("t6_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("t6_rst_wr_abort", 64'(wr_abort), 64'd0);
    step(); step();
    rst = 1'b0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mcbsp_rx_frame_buf.md
MCBSP_RX_FRAME_BUF -- requirements
Module: mcbsp_rx_frame_buf

Interface
REQ-001 Parameter FRAME_WORDS, default 721, 32-bit words per hop frame; legal range 2..1024.
REQ-002 Parameter ADDR_W, default 10, per-bank address width; 2**ADDR_W SHALL be >= FRAME_WORDS.
REQ-003 clk  in  1  system clock, 200 MHz.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rx_ready  in  1  word-ready level from McBSP receiver, clk-synchronous, high for one or more cycles per word.
REQ-006 rx_data_in  in  32  received word; stable while rx_ready is high.
REQ-007 transform_en  in  1  DSP transfer enable; low aborts the frame being filled.
REQ-008 out_ready  in  1  downstream accepts out_data.
REQ-009 ovf_clr  in  1  single-cycle clear of overflow and drop_cnt.
REQ-010 out_data  out  32  frame word to downstream.
REQ-011 out_valid  out  1  out_data valid.
REQ-012 out_sof / out_eof  out  1 each  first / last word of frame, qualified by out_valid.
REQ-013 bank_full  out  2  per-bank full flags.
REQ-014 frame_cnt  out  16  completed frames, wraps 0xFFFF->0.
REQ-015 overflow  out  1  sticky, word dropped.
REQ-016 drop_cnt  out  16  dropped words, saturates at 0xFFFF.
REQ-017 wr_abort  out  1  one-cycle pulse, partial frame discarded.

Function
REQ-018 Word strobe SHALL be rx_ready high and previous-cycle rx_ready low; one word per rising edge regardless of level duration.
REQ-019 Storage: two banks of 2**ADDR_W x 32, synchronous write, synchronous read (1-cycle latency).
REQ-020 Writer FSM W_IDLE, W_FILL; W_IDLE -> W_FILL when transform_en=1; strobes in W_IDLE ignored.
REQ-021 W_FILL strobe with bank_full[wr_bank]=0: write rx_data_in to mem[wr_bank][wr_ptr], wr_ptr+1.
REQ-022 Strobe writing wr_ptr=FRAME_WORDS-1: next cycle bank_full[wr_bank]=1, wr_bank toggles, wr_ptr=0, frame_cnt+1.
REQ-023 W_FILL strobe with bank_full[wr_bank]=1: word dropped, overflow=1, drop_cnt+1 (saturating), wr_ptr unchanged.
REQ-024 transform_en=0 in W_FILL: wr_ptr=0, wr_bank unchanged, -> W_IDLE; wr_abort pulses only if wr_ptr!=0.
REQ-025 Strobe coinciding with transform_en falling: word discarded, abort rule applies.
REQ-026 Reader FSM R_IDLE, R_READ, R_HOLD; R_IDLE -> R_READ when bank_full[rd_bank]=1, rd_ptr=0.
REQ-027 R_READ: present address {rd_bank,rd_ptr}; next cycle out_data latched, out_valid=1, -> R_HOLD.
REQ-028 R_HOLD: out_data/flags held while out_ready=0; out_sof=(rd_ptr==0), out_eof=(rd_ptr==FRAME_WORDS-1).
REQ-029 R_HOLD with out_ready=1: out_valid=0 next cycle; if eof, bank_full[rd_bank] cleared, rd_bank toggles, -> R_IDLE; else rd_ptr+1, -> R_READ.
REQ-030 Throughput: at most one word per 2 clk; first out_valid 2 clk after bank_full rises.
REQ-031 bank_full set (writer) and clear (reader) on different banks in same cycle both take effect; writer tests registered bank_full, so a strobe in the clearing cycle is dropped.
REQ-032 ovf_clr clears overflow and drop_cnt; simultaneous drop: clear wins, drop not counted.
REQ-033 Frames emitted in completion order; banks alternate strictly starting at bank 0.

Reset
REQ-034 rst SHALL asynchronously force: both FSMs idle, wr_bank=rd_bank=0, pointers 0, all outputs 0; memory contents undefined.
REQ-035 rst mid-frame discards all buffered and partial data; no wr_abort pulse.

Verification
REQ-036 FRAME_WORDS=4, transform_en=1, 4 strobes 0xA0..0xA3, out_ready=1 -> out_data A0..A3, sof on A0, eof on A3, frame_cnt=1, bank_full returns 00.
REQ-037 rx_ready held high 10 cycles per word -> exactly one write per pulse, FRAME_WORDS words per frame.
REQ-038 out_ready=0, 3 frames of 4 words -> bank_full=11, 4 drops, overflow=1, drop_cnt=4; ovf_clr -> both 0.
REQ-039 transform_en low after 2 words -> wr_abort one pulse, next frame starts at wr_ptr 0, no stale words output.
REQ-040 out_ready toggled randomly -> out_data stable while out_valid & !out_ready, no word lost/duplicated.
REQ-041 rst asserted with out_valid=1 -> out_valid, bank_full, frame_cnt immediately 0.
